mod_timing_ctrl: RTL and testbench
==================================

Name: mod_timing_ctrl

Overview:
- Sequencer for the modulation datapath.
- Owns the two-segment modulation schedule. From a periodic TICK strobe it produces the BRAM read index, the active segment and the stop flag that the modulation multiplier consumes.
- Handles segment-swap requests with the transition modes IMMEDIATE, SYNC_IDX and SYS_TIME, and applies the per-segment frequency divider and repeat count.
- Sits between the settings register block and the modulation datapath.

Parameters:
- IDX_WIDTH, 15: width of CYCLE and IDX; max modulation length 2^15.
- DIV_WIDTH, 16: width of FREQ_DIV.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous active-low reset, sampled on CLK rising edge.
- TICK  in  1  one-cycle strobe, one modulation base period.
- SYS_TIME  in  64  system time.
- UPDATE  in  1  one-cycle request strobe.
- REQ_RD_SEGMENT  in  1  requested segment.
- TRANSITION_MODE  in  2  0=SYNC_IDX, 1=IMMEDIATE, 2=SYS_TIME, 3=reserved (treated as IMMEDIATE).
- TRANSITION_VALUE  in  64  SYS_TIME threshold for mode 2.
- CYCLE_0, CYCLE_1  in  IDX_WIDTH each  last index (length-1) of segment 0 / segment 1.
- FREQ_DIV_0, FREQ_DIV_1  in  DIV_WIDTH each  ticks per index step; 0 is treated as 1.
- REP_0, REP_1  in  32 each  extra loops; 32'hFFFFFFFF means infinite.
- IDX  out  IDX_WIDTH  current read index.
- SEGMENT  out  1  active segment.
- STOP  out  1  1 = playback finished; datapath uses entry CYCLE of SEGMENT.
- PENDING  out  1  a swap request is waiting.

Behaviour:
- Reset:
  - IDX=0, SEGMENT=0, STOP=1, PENDING=0.
  - All counters 0; state IDLE.
  - Reset mid-operation discards any pending request.
- Shadow latch:
  - On UPDATE, latch REQ_RD_SEGMENT, mode, TRANSITION_VALUE, and the requested segment's CYCLE/FREQ_DIV/REP into pending registers.
  - Set PENDING=1 the next cycle.
  - A new UPDATE while PENDING overwrites the request; the last one wins.
  - UPDATE in the same cycle as the swap of an older request: the swap completes, then the new request becomes pending.
- States:
  - IDLE: no segment started; STOP=1. The first pending request swaps on the next TICK regardless of mode.
  - RUN: on each TICK, increment the div counter. When div counter = FREQ_DIV-1:
    - div counter returns to 0.
    - If IDX=CYCLE: IDX wraps to 0 and the loop counter increments; otherwise IDX increments.
  - STOPPED: reached when, at a wrap, loop counter = REP (REP not infinite). IDX holds CYCLE, STOP=1, and TICKs are ignored except for swap evaluation.
- Swap conditions (evaluated only on TICK, with PENDING=1):
  - IMMEDIATE: swap on the next TICK.
  - SYNC_IDX: swap on the TICK that would wrap IDX from CYCLE to 0. In STOPPED/IDLE, swap on the next TICK.
  - SYS_TIME: swap on the first TICK with SYS_TIME >= TRANSITION_VALUE (unsigned 64-bit). A past value swaps on the next TICK.
- Swap action, same cycle:
  - SEGMENT=requested; IDX=0, div counter 0, loop counter 0.
  - STOP=0, PENDING=0; active CYCLE/FREQ_DIV/REP loaded from pending; state RUN.
  - Swapping to the already active segment restarts it.
- Latency: outputs are registered and change in the cycle after the TICK edge. No outputs change without TICK, except PENDING.
- Arithmetic:
  - Loop counter is 32-bit and never wraps; REP=32'hFFFFFFFF never stops.
  - CYCLE=0 gives a 1-entry segment; each index step is a wrap.

Test Plan:
- Reset, then no UPDATE for 100 TICKs -> IDX=0, SEGMENT=0, STOP=1, PENDING=0 throughout.
- UPDATE seg0 IMMEDIATE, CYCLE_0=9, FREQ_DIV_0=1, REP_0=FFFFFFFF -> after next TICK IDX=0, STOP=0. IDX then follows 0..9,0.. one step per TICK, never stops over 50 TICKs.
- Running seg0 at IDX=5: UPDATE seg1 SYNC_IDX, CYCLE_1=4, FREQ_DIV_1=2, REP_1=0 -> PENDING=1. Swap on the TICK where seg0 would wrap (after IDX=9). IDX then goes 0,0,1,1,..,4,4; then STOP=1 with IDX=4 held.
- From STOPPED seg1: UPDATE seg0 SYNC_IDX, REP_0=1 -> swap on the next TICK. Exactly 2 loops of 0..9, then STOP=1, IDX=9, SEGMENT=0.
- SYS_TIME mode with TRANSITION_VALUE = current SYS_TIME+1000 -> no swap on TICKs before the threshold. Swap on the first TICK with SYS_TIME >= value. A second UPDATE before then replaces the target segment.
- FREQ_DIV=0 and CYCLE=0 -> behaves as divide-by-1; IDX stays 0 and the loop count increments every TICK. REP=3 gives STOP after 4 TICKs.

Source files
------------

// File: rtl/mod_timing_ctrl_if.sv
// Settings-to-sequencer bus for the modulation timing controller.
// The settings block drives requests and timing as master; the sequencer reports playback state as slave.
interface mod_timing_ctrl_if #(
    parameter int IDX_WIDTH = 15,
    parameter int DIV_WIDTH = 16
);
    logic                 TICK;
    logic [63:0]          SYS_TIME;
    logic                 UPDATE;
    logic                 REQ_RD_SEGMENT;
    logic [1:0]           TRANSITION_MODE;
    logic [63:0]          TRANSITION_VALUE;
    logic [IDX_WIDTH-1:0] CYCLE_0;
    logic [IDX_WIDTH-1:0] CYCLE_1;
    logic [DIV_WIDTH-1:0] FREQ_DIV_0;
    logic [DIV_WIDTH-1:0] FREQ_DIV_1;
    logic [31:0]          REP_0;
    logic [31:0]          REP_1;
    logic [IDX_WIDTH-1:0] IDX;
    logic                 SEGMENT;
    logic                 STOP;
    logic                 PENDING;

    modport master (
        output TICK, SYS_TIME, UPDATE, REQ_RD_SEGMENT, TRANSITION_MODE, TRANSITION_VALUE,
               CYCLE_0, CYCLE_1, FREQ_DIV_0, FREQ_DIV_1, REP_0, REP_1,
        input  IDX, SEGMENT, STOP, PENDING
    );

    modport slave (
        input  TICK, SYS_TIME, UPDATE, REQ_RD_SEGMENT, TRANSITION_MODE, TRANSITION_VALUE,
               CYCLE_0, CYCLE_1, FREQ_DIV_0, FREQ_DIV_1, REP_0, REP_1,
        output IDX, SEGMENT, STOP, PENDING
    );
endinterface

// File: rtl/mod_timing_ctrl.sv
// Two-segment modulation sequencer: turns TICK into BRAM index, active segment and stop flag,
// and swaps segments on request using IMMEDIATE, SYNC_IDX or SYS_TIME transitions.
module mod_timing_ctrl #(
    parameter int IDX_WIDTH = 15,
    parameter int DIV_WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    mod_timing_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    localparam logic [1:0]           MODE_SYNC_IDX = 2'd0;
    localparam logic [1:0]           MODE_SYS_TIME = 2'd2;
    localparam logic [31:0]          REP_INFINITE  = 32'hFFFF_FFFF;
    localparam logic [31:0]          LOOP_ONE      = 32'd1;
    localparam logic [IDX_WIDTH-1:0] IDX_ONE       = IDX_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE       = DIV_WIDTH'(1);

    // Control state, reset
    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                 seg_q, seg_d;
    logic                 stop_q, stop_d;
    logic                 pend_q, pend_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [31:0]          loop_cnt_q, loop_cnt_d;

    // Segment parameters, only meaningful once a swap or latch has qualified them
    logic [IDX_WIDTH-1:0] act_cycle_q, act_cycle_d;
    logic [DIV_WIDTH-1:0] act_div_q, act_div_d;
    logic [31:0]          act_rep_q, act_rep_d;
    logic                 pend_seg_q, pend_seg_d;
    logic [1:0]           pend_mode_q, pend_mode_d;
    logic [63:0]          pend_tv_q, pend_tv_d;
    logic [IDX_WIDTH-1:0] pend_cycle_q, pend_cycle_d;
    logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
    logic [31:0]          pend_rep_q, pend_rep_d;

    logic swap;
    logic step;
    logic at_end;
    logic wrap;

    // A divider of 0 behaves as divide-by-1, so its last count is 0 as well.
    function automatic logic [DIV_WIDTH-1:0] div_last(input logic [DIV_WIDTH-1:0] div);
        return (div == '0) ? '0 : (div - DIV_ONE);
    endfunction

    function automatic logic [31:0] loop_inc(input logic [31:0] cnt);
        return (cnt == '1) ? cnt : (cnt + LOOP_ONE);
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        seg_d        = seg_q;
        stop_d       = stop_q;
        pend_d       = pend_q;
        div_cnt_d    = div_cnt_q;
        loop_cnt_d   = loop_cnt_q;
        act_cycle_d  = act_cycle_q;
        act_div_d    = act_div_q;
        act_rep_d    = act_rep_q;
        pend_seg_d   = pend_seg_q;
        pend_mode_d  = pend_mode_q;
        pend_tv_d    = pend_tv_q;
        pend_cycle_d = pend_cycle_q;
        pend_div_d   = pend_div_q;
        pend_rep_d   = pend_rep_q;
        swap         = 1'b0;

        step   = (div_cnt_q == div_last(act_div_q));
        at_end = (idx_q == act_cycle_q);
        wrap   = (state_q == ST_RUN) && step && at_end;

        if (bus.TICK && pend_q) begin
            unique case (pend_mode_q)
                MODE_SYNC_IDX: swap = (state_q != ST_RUN) || wrap;
                MODE_SYS_TIME: swap = (state_q == ST_IDLE) || (bus.SYS_TIME >= pend_tv_q);
                default:       swap = 1'b1;
            endcase
        end

        if (swap) begin
            state_d     = ST_RUN;
            seg_d       = pend_seg_q;
            idx_d       = '0;
            stop_d      = 1'b0;
            div_cnt_d   = '0;
            loop_cnt_d  = '0;
            act_cycle_d = pend_cycle_q;
            act_div_d   = pend_div_q;
            act_rep_d   = pend_rep_q;
        end else if (bus.TICK && (state_q == ST_RUN)) begin
            if (!step) begin
                div_cnt_d = div_cnt_q + DIV_ONE;
            end else begin
                div_cnt_d = '0;
                if (!at_end) begin
                    idx_d = idx_q + IDX_ONE;
                end else if ((act_rep_q != REP_INFINITE) && (loop_cnt_q == act_rep_q)) begin
                    // Final pass done: hold the last entry for the datapath.
                    state_d = ST_STOPPED;
                    stop_d  = 1'b1;
                end else begin
                    idx_d      = '0;
                    loop_cnt_d = loop_inc(loop_cnt_q);
                end
            end
        end

        // A fresh request lands after any swap of the older one in the same cycle.
        if (bus.UPDATE) begin
            pend_d       = 1'b1;
            pend_seg_d   = bus.REQ_RD_SEGMENT;
            pend_mode_d  = bus.TRANSITION_MODE;
            pend_tv_d    = bus.TRANSITION_VALUE;
            pend_cycle_d = bus.REQ_RD_SEGMENT ? bus.CYCLE_1    : bus.CYCLE_0;
            pend_div_d   = bus.REQ_RD_SEGMENT ? bus.FREQ_DIV_1 : bus.FREQ_DIV_0;
            pend_rep_d   = bus.REQ_RD_SEGMENT ? bus.REP_1      : bus.REP_0;
        end else if (swap) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            seg_q      <= 1'b0;
            stop_q     <= 1'b1;
            pend_q     <= 1'b0;
            div_cnt_q  <= '0;
            loop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            stop_q     <= stop_d;
            pend_q     <= pend_d;
            div_cnt_q  <= div_cnt_d;
            loop_cnt_q <= loop_cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        act_cycle_q  <= act_cycle_d;
        act_div_q    <= act_div_d;
        act_rep_q    <= act_rep_d;
        pend_seg_q   <= pend_seg_d;
        pend_mode_q  <= pend_mode_d;
        pend_tv_q    <= pend_tv_d;
        pend_cycle_q <= pend_cycle_d;
        pend_div_q   <= pend_div_d;
        pend_rep_q   <= pend_rep_d;
    end

    assign bus.IDX     = idx_q;
    assign bus.SEGMENT = seg_q;
    assign bus.STOP    = stop_q;
    assign bus.PENDING = pend_q;

endmodule

// File: tb/tb_mod_timing_ctrl.sv
// Bench for mod_timing_ctrl: directed segment/transition scenarios checked every cycle against
// a tick-count model of the schedule, plus literal expectations on DUT and model.
module tb_mod_timing_ctrl;
    localparam int IW = 15;
    localparam int DW = 16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [63:0] sys_cnt = 64'h0000_0001_0000_0000;
    bit          chk_en = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    mod_timing_ctrl_if #(.IDX_WIDTH(IW), .DIV_WIDTH(DW)) bus ();

    mod_timing_ctrl #(.IDX_WIDTH(IW), .DIV_WIDTH(DW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(negedge CLK) sys_cnt = sys_cnt + 64'd1;
    assign bus.SYS_TIME = sys_cnt;

    // Model: the schedule is a function of ticks elapsed since the last swap.
    bit              m_started = 1'b0;
    bit              m_seg = 1'b0;
    longint unsigned m_n = 0;
    longint unsigned m_cyc = 0, m_div = 0, m_rep = 0;
    bit              m_pend = 1'b0;
    bit              m_pseg = 1'b0;
    logic [1:0]      m_pmode = 2'd0;
    longint unsigned m_ptv = 0, m_pcyc = 0, m_pdiv = 0, m_prep = 0;

    function automatic longint unsigned eff_div(input longint unsigned d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic bit m_stopped();
        if (!m_started) return 1'b1;
        if (m_rep == 64'hFFFF_FFFF) return 1'b0;
        return (m_n / eff_div(m_div)) >= (m_cyc + 1) * (m_rep + 1);
    endfunction

    function automatic longint unsigned m_idx();
        if (!m_started) return 0;
        if (m_stopped()) return m_cyc;
        return (m_n / eff_div(m_div)) % (m_cyc + 1);
    endfunction

    always @(posedge CLK) begin
        if (!RST_N) begin
            m_started = 1'b0;
            m_seg     = 1'b0;
            m_pend    = 1'b0;
            m_n       = 0;
        end else begin
            bit              sw;
            longint unsigned n1, d;
            sw = 1'b0;
            if (bus.TICK && m_pend) begin
                d  = eff_div(m_div);
                n1 = m_n + 1;
                case (m_pmode)
                    2'd0: sw = !m_started || m_stopped() ||
                               (((n1 % d) == 0) && (((n1 / d) % (m_cyc + 1)) == 0));
                    2'd2: sw = !m_started || (bus.SYS_TIME >= m_ptv);
                    default: sw = 1'b1;
                endcase
            end
            if (sw) begin
                m_seg     = m_pseg;
                m_cyc     = m_pcyc;
                m_div     = m_pdiv;
                m_rep     = m_prep;
                m_n       = 0;
                m_started = 1'b1;
                m_pend    = 1'b0;
            end else if (bus.TICK && m_started) begin
                m_n = m_n + 1;
            end
            if (bus.UPDATE) begin
                m_pend  = 1'b1;
                m_pseg  = bus.REQ_RD_SEGMENT;
                m_pmode = bus.TRANSITION_MODE;
                m_ptv   = bus.TRANSITION_VALUE;
                m_pcyc  = bus.REQ_RD_SEGMENT ? 64'(bus.CYCLE_1)    : 64'(bus.CYCLE_0);
                m_pdiv  = bus.REQ_RD_SEGMENT ? 64'(bus.FREQ_DIV_1) : 64'(bus.FREQ_DIV_0);
                m_prep  = bus.REQ_RD_SEGMENT ? 64'(bus.REP_1)      : 64'(bus.REP_0);
            end
        end
    end

    // Literal expectations posted by the stimulus, consumed by the compare process.
    string           lit_nm [256];
    int              lit_sel[256];
    longint unsigned lit_val[256];
    int              lit_wr = 0;
    int              lit_rd = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        logic [63:0] a;
        logic [63:0] m;
        if (chk_en) begin
            check("idx",     64'(bus.IDX),     m_idx());
            check("segment", 64'(bus.SEGMENT), 64'(m_seg));
            check("stop",    64'(bus.STOP),    64'(m_stopped()));
            check("pending", 64'(bus.PENDING), 64'(m_pend));
            while (lit_rd < lit_wr) begin
                case (lit_sel[lit_rd])
                    0:       begin a = 64'(bus.IDX);     m = m_idx();           end
                    1:       begin a = 64'(bus.SEGMENT); m = 64'(m_seg);        end
                    2:       begin a = 64'(bus.STOP);    m = 64'(m_stopped());  end
                    default: begin a = 64'(bus.PENDING); m = 64'(m_pend);       end
                endcase
                check({lit_nm[lit_rd], "_dut"},   a, lit_val[lit_rd]);
                check({lit_nm[lit_rd], "_model"}, m, lit_val[lit_rd]);
                lit_rd++;
            end
        end
    end

    task automatic lit(input string nm, input int sel, input longint unsigned val);
        @(posedge CLK);
        #1;
        lit_nm[lit_wr]  = nm;
        lit_sel[lit_wr] = sel;
        lit_val[lit_wr] = val;
        lit_wr++;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK); bus.TICK = 1'b1;
            @(negedge CLK); bus.TICK = 1'b0;
        end
    endtask

    task automatic do_update(input bit seg, input logic [1:0] mode, input logic [63:0] tv,
                             input bit with_tick);
        @(negedge CLK);
        bus.UPDATE           = 1'b1;
        bus.REQ_RD_SEGMENT   = seg;
        bus.TRANSITION_MODE  = mode;
        bus.TRANSITION_VALUE = tv;
        bus.TICK             = with_tick;
        @(negedge CLK);
        bus.UPDATE = 1'b0;
        bus.TICK   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] tv;
        bus.TICK = 1'b0;           bus.UPDATE = 1'b0;
        bus.REQ_RD_SEGMENT = 1'b0; bus.TRANSITION_MODE = 2'd0;
        bus.TRANSITION_VALUE = '0;
        bus.CYCLE_0 = '0;          bus.CYCLE_1 = '0;
        bus.FREQ_DIV_0 = '0;       bus.FREQ_DIV_1 = '0;
        bus.REP_0 = '0;            bus.REP_1 = '0;
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N  = 1'b1;
        chk_en = 1'b1;

        // Idle after reset: nothing moves without a request.
        lit("rst_idx", 0, 0); lit("rst_stop", 2, 1); lit("rst_pend", 3, 0);
        tick_n(100);
        lit("idle_idx", 0, 0); lit("idle_seg", 1, 0); lit("idle_stop", 2, 1);

        // Segment 0, 10 entries, divide-by-1, endless.
        bus.CYCLE_0 = 15'd9; bus.FREQ_DIV_0 = 16'd1; bus.REP_0 = 32'hFFFF_FFFF;
        do_update(1'b0, 2'd1, 64'd0, 1'b0);
        lit("imm_pend", 3, 1);
        tick_n(1);
        lit("imm_idx", 0, 0); lit("imm_stop", 2, 0); lit("imm_pend_clr", 3, 0);
        tick_n(55);
        lit("run_idx5", 0, 5); lit("run_stop", 2, 0);

        // Sync swap to segment 1 at the wrap of segment 0.
        bus.CYCLE_1 = 15'd4; bus.FREQ_DIV_1 = 16'd2; bus.REP_1 = 32'd0;
        do_update(1'b1, 2'd0, 64'd0, 1'b0);
        lit("sync_pend", 3, 1);
        tick_n(4);
        lit("sync_pre_idx", 0, 9); lit("sync_pre_seg", 1, 0);
        tick_n(1);
        lit("sync_seg", 1, 1); lit("sync_idx", 0, 0);
        tick_n(3);
        lit("div2_idx", 0, 1);
        tick_n(7);
        lit("s1_stop", 2, 1); lit("s1_idx", 0, 4);
        tick_n(3);
        lit("s1_hold_idx", 0, 4); lit("s1_hold_seg", 1, 1);

        // From STOPPED, sync request swaps on the next tick; two loops then stop.
        bus.REP_0 = 32'd1;
        do_update(1'b0, 2'd0, 64'd0, 1'b0);
        tick_n(1);
        lit("s0_seg", 1, 0); lit("s0_stop", 2, 0);
        tick_n(19);
        lit("s0_last_idx", 0, 9); lit("s0_last_stop", 2, 0);
        tick_n(1);
        lit("s0_end_stop", 2, 1); lit("s0_end_idx", 0, 9);

        // SYS_TIME threshold, target replaced before it is reached.
        tv = sys_cnt + 64'd1000;
        do_update(1'b0, 2'd2, tv, 1'b0);
        tick_n(100);
        lit("st_wait_pend", 3, 1); lit("st_wait_stop", 2, 1);
        bus.CYCLE_1 = 15'd4; bus.FREQ_DIV_1 = 16'd1; bus.REP_1 = 32'hFFFF_FFFF;
        do_update(1'b1, 2'd2, tv, 1'b0);
        for (int i = 0; i < 700; i++) begin
            tick_n(1);
            if (bus.STOP == 1'b0) break;
        end
        lit("st_swap_stop", 2, 0); lit("st_swap_seg", 1, 1); lit("st_swap_pend", 3, 0);

        // Divider 0 and a single-entry segment: one loop per tick.
        bus.CYCLE_0 = 15'd0; bus.FREQ_DIV_0 = 16'd0; bus.REP_0 = 32'd3;
        do_update(1'b0, 2'd1, 64'd0, 1'b0);
        tick_n(1);
        lit("one_seg", 1, 0); lit("one_idx", 0, 0); lit("one_stop", 2, 0);
        tick_n(3);
        lit("one_run", 2, 0);
        tick_n(1);
        lit("one_end_stop", 2, 1); lit("one_end_idx", 0, 0);

        // Reset with a request waiting discards it.
        do_update(1'b1, 2'd0, 64'd0, 1'b0);
        lit("pre_rst_pend", 3, 1);
        @(negedge CLK); RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        lit("mid_rst_pend", 3, 0); lit("mid_rst_stop", 2, 1); lit("mid_rst_seg", 1, 0);

        // New request in the same cycle as a swap becomes the next pending one.
        bus.CYCLE_0 = 15'd9; bus.FREQ_DIV_0 = 16'd1; bus.REP_0 = 32'hFFFF_FFFF;
        do_update(1'b0, 2'd1, 64'd0, 1'b0);
        do_update(1'b1, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        lit("ovl_seg", 1, 0); lit("ovl_stop", 2, 0); lit("ovl_pend", 3, 1);
        tick_n(3);
        lit("ovl_idx", 0, 3); lit("ovl_pend_hold", 3, 1);

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
